// File: rtl/bit_gather_pkg.sv
// Shared constants and helpers for the lane-bit gather/packer.
// Derivations live here so the top, the bus and the FIFO agree on widths.
package bit_gather_pkg;

  localparam int DEF_IN_W       = 128;
  localparam int DEF_LANE_W     = 16;
  localparam int DEF_PACK       = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    int num_lanes;
    int out_w;
    int cnt_w;
  } dims_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic dims_t derive(
    input int in_w,
    input int lane_w,
    input int pack
  );
    dims_t d;
    d.num_lanes = in_w / lane_w;
    d.out_w     = d.num_lanes * pack;
    d.cnt_w     = clog2(pack + 1);
    return d;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bit_gather_if.sv
// Block-in / packed-word-out bus of the gather packer.
// master drives blocks and consumes words; slave is the packer.
interface bit_gather_if
  import bit_gather_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int LANE_W = DEF_LANE_W,
  parameter int PACK   = DEF_PACK
);

  localparam dims_t D     = derive(IN_W, LANE_W, PACK);
  localparam int    OUT_W = D.out_w;
  localparam int    CNT_W = D.cnt_w;
  localparam int    SEL_W = (clog2(LANE_W) < 1) ? 1
                                                : clog2(LANE_W);

  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic [SEL_W-1:0]  sel_bit;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              overflow;
  logic              clr_overflow;
  logic              busy;

  modport master (
    output in_valid, in_data, sel_bit, flush,
    output out_ready, clr_overflow,
    input  out_valid, out_data, out_count,
    input  overflow, busy
  );

  modport slave (
    input  in_valid, in_data, sel_bit, flush,
    input  out_ready, clr_overflow,
    output out_valid, out_data, out_count,
    output overflow, busy
  );

endinterface

// File: rtl/bit_gather_packer_fifo.sv
// Show-ahead synchronous FIFO for packed words.
// Head is always visible; push+pop when full is accepted.
module gather_fifo
  import bit_gather_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("gather_fifo: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rp_q];

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + AW'(1);
    end
    if (do_pop) rp_d = rp_q + AW'(1);
    unique case (1'b1)
      (do_push & ~do_pop): cnt_d = cnt_q + (AW+1)'(1);
      (do_pop & ~do_push): cnt_d = cnt_q - (AW+1)'(1);
      default:             cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_gather_packer.sv
// Gathers one selected bit per lane of each block and packs
// PACK such groups per word into a show-ahead output FIFO.
module bit_gather_packer
  import bit_gather_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int PACK       = DEF_PACK,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic        clk,
  input logic        rst_n,
  bit_gather_if.slave bus
);

  localparam dims_t D         = derive(IN_W, LANE_W, PACK);
  localparam int    NUM_LANES = D.num_lanes;
  localparam int    OUT_W     = D.out_w;
  localparam int    CNT_W     = D.cnt_w;

  if ((IN_W % LANE_W) != 0 || IN_W < LANE_W ||
      !is_pow2(LANE_W) || PACK < 1 ||
      !is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_param
    $error("bit_gather_packer: illegal parameter set");
  end

  logic [NUM_LANES-1:0] pick;
  logic [NUM_LANES-1:0] g_q, g_d;
  logic                 gv_q, fl_q;
  logic [OUT_W-1:0]     acc_q, acc_d, acc_n;
  logic [CNT_W-1:0]     grp_q, grp_d, grp_n;
  logic                 ov_q, ov_d;
  logic                 push;
  logic [CNT_W-1:0]     push_cnt;
  logic                 pop;
  logic                 full, empty;
  logic [OUT_W+CNT_W-1:0] rdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane;
    assign lane    = bus.in_data[i*LANE_W +: LANE_W];
    assign pick[i] = lane[bus.sel_bit];
  end

  assign g_d = bus.in_valid ? pick : g_q;

  // Flush acts on the accumulator after any same-cycle group lands.
  always_comb begin
    acc_n    = acc_q;
    grp_n    = grp_q;
    push     = 1'b0;
    push_cnt = '0;
    if (gv_q) begin
      for (int k = 0; k < PACK; k++) begin
        if (grp_q == CNT_W'(k))
          acc_n[k*NUM_LANES +: NUM_LANES] = g_q;
      end
      if (grp_q == CNT_W'(PACK - 1)) begin
        push     = 1'b1;
        push_cnt = CNT_W'(PACK);
      end else begin
        grp_n = grp_q + CNT_W'(1);
      end
    end
    if (!push && fl_q && grp_n != '0) begin
      push     = 1'b1;
      push_cnt = grp_n;
    end
    acc_d = push ? '0 : acc_n;
    grp_d = push ? '0 : grp_n;
  end

  assign pop = ~empty & bus.out_ready;

  always_comb begin
    ov_d = ov_q;
    if (bus.clr_overflow) ov_d = 1'b0;
    if (push & full & ~pop) ov_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q   <= '0;
      gv_q  <= 1'b0;
      fl_q  <= 1'b0;
      acc_q <= '0;
      grp_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      g_q   <= g_d;
      gv_q  <= bus.in_valid;
      fl_q  <= bus.flush;
      acc_q <= acc_d;
      grp_q <= grp_d;
      ov_q  <= ov_d;
    end
  end

  gather_fifo #(
    .W     (OUT_W + CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({push_cnt, acc_n}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_count = rdata[OUT_W +: CNT_W];
  assign bus.out_data  = rdata[OUT_W-1:0];
  assign bus.overflow  = ov_q;
  assign bus.busy      = gv_q | fl_q | (grp_q != '0) | ~empty;

endmodule

// File: doc/bit_gather_packer.md
Name: bit_gather_packer

Overview:
- Parametrised lane-bit extractor and packer that sits after the AES decrypt core.
- On each in_valid pulse it takes one selected bit from every LANE_W-bit lane of the decrypted block. This produces one NUM_LANES-bit group.
- It packs PACK consecutive groups into one OUT_W word and buffers the words in a small show-ahead FIFO. The downstream side drains the FIFO through a valid/ready interface.
- Adds runtime bit select, multi-block packing, flush of partial words, backpressure and overflow reporting.

Parameters:
- IN_W, 128, input block width; must be a multiple of LANE_W.
- LANE_W, 16, lane width; must be a power of two.
- PACK, 4, groups per output word; must be at least 1.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two and at least 2.
- Derived localparams: NUM_LANES=IN_W/LANE_W (8), OUT_W=NUM_LANES*PACK (32), SEL_W=clog2(LANE_W) (4), CNT_W=clog2(PACK+1) (3).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  single-cycle pulse, block available; no backpressure
- in_data  in  IN_W  decrypted block, valid with in_valid
- sel_bit  in  SEL_W  bit index within each lane, sampled with in_valid
- flush  in  1  pulse, emit the partial word
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head word
- out_data  out  OUT_W  head word
- out_count  out  CNT_W  number of valid groups in the head word
- overflow  out  1  sticky, a word was dropped
- clr_overflow  in  1  clears overflow
- busy  out  1  data in flight or buffered

Behaviour:
- Reset: out_valid=0, out_data=0, out_count=0, overflow=0, busy=0; FIFO empty; accumulator and group counter grp cleared. Reset mid-operation discards partial words and all FIFO contents.
- Gather (stage 1, registered): on in_valid, g_q[i] <= in_data[i*LANE_W + sel_bit] for i in 0..NUM_LANES-1. Also gv_q <= in_valid and fl_q <= flush.
  - With sel_bit=3 and the default parameters, g_q[7]=in_data[115] and g_q[0]=in_data[3].
- Pack (stage 2): when gv_q=1, the group goes to acc[grp*NUM_LANES +: NUM_LANES], with the first group in the lowest bits.
  - If grp==PACK-1: push {group, acc lower bits} with count=PACK, then set grp=0 and clear acc.
  - Otherwise grp++.
- Flush: applied in stage 2 together with fl_q, after any same-cycle group is absorbed. A flush in the same cycle as an in_valid therefore includes that group.
  - If the resulting grp>0: push acc with the upper groups zero and count=grp, then set grp=0 and clear acc.
  - If grp==0: no-op.
  - If the same-cycle group completes the word: exactly one push, count=PACK.
- Latency: a completing in_valid at cycle t gives out_valid=1 in cycle t+2 when the FIFO is empty.
- At most one push per cycle.
- FIFO: show-ahead, so out_data/out_count always present the head entry. A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full; no overflow results.
  - Push while full with no pop: the word is dropped, overflow<=1, grp and acc still reset so alignment is kept.
  - Pop while empty: ignored.
  - out_data/out_count hold their value while out_valid & !out_ready.
- overflow: set has priority over clr_overflow in the same cycle.
- busy = gv_q | fl_q | (grp!=0) | out_valid.
- in_valid pulses may be back-to-back, one block per cycle, with no stall.
- Elaboration must fail if any parameter constraint is violated.

Decomposition:
- Package bit_gather_pkg holds:
  - default parameter constants (IN_W, LANE_W, PACK, FIFO_DEPTH);
  - a clog2 function;
  - a constant function computing the NUM_LANES/OUT_W/CNT_W derivations.
- One sub-module, gather_fifo: a parametrised show-ahead synchronous FIFO with width OUT_W+CNT_W and depth FIFO_DEPTH. It reports full and empty and accepts push and pop in the same cycle when full.
- Gather logic and packer stay in the top level.

Test Plan:
- Pack 4 groups, sel_bit=3, out_ready=1:
  - Stimulus: 4 back-to-back blocks: all lanes 16'h0008; all zero; all lanes 16'h0008; lanes 0-3 16'h0008 and lanes 4-7 zero.
  - Response: out_data=32'h0FFF00FF, out_count=4, out_valid exactly 2 cycles after the 4th in_valid, for 1 cycle.
- sel_bit=15:
  - Stimulus: lanes 1,3,5,7 = 16'h8000, others 16'h7FFF, 4 times.
  - Response: out_data=32'hAAAAAAAA.
- Flush:
  - Stimulus: groups 8'h12 then 8'h34, then flush.
  - Response: out_data=32'h00003412, out_count=2.
  - A second flush with grp=0 produces no output.
  - A flush coincident with the 3rd group gives count=3.
- Backpressure:
  - Stimulus: out_ready=0, push 5 full words.
  - Response: 4 words retained and the 5th dropped; overflow=1 and busy=1.
  - Raise out_ready: the 4 words drain in order, then out_valid=0.
  - Pulse clr_overflow: overflow returns to 0.
- Full boundary:
  - Stimulus: FIFO full, out_ready=1 in the cycle a new word is pushed.
  - Response: overflow stays 0, occupancy stays 4, order is preserved.
- Reset mid-accumulation:
  - Stimulus: 3 groups, then rst_n low for 2 cycles.
  - Response: all outputs return to 0.
  - The next 4 groups form a clean word with count=4 and no residue.
